// File: rtl/labb_arbiter.sv
// labb_arbiter: round-robin arbiter that lends one shared 2-to-4 decoder to
// two four-phase requesters. The granted code drives the decoder for HOLD
// cycles, and the decoder result is then captured and acknowledged.
module labb_arbiter #(
  parameter int HOLD = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] code0,
  input  logic [1:0] code1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] res,
  output logic       da,
  output logic       db,
  input  logic       dw,
  input  logic       dx,
  input  logic       dy,
  input  logic       dz,
  output logic       busy,
  output logic       gnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       ptr;       // requester favoured when both ask at once
  logic       any_req;
  logic       win;       // requester that would be granted this edge
  logic       gnt_req;   // request line of the requester currently granted
  logic       grant_go;
  logic       cap_go;
  logic       rel_go;

  assign any_req = req0 | req1;
  assign win     = (req0 & req1) ? ptr : req1;
  assign gnt_req = gnt ? req1 : req0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)   state_next = DRIVE;
      DRIVE:   if (cnt == '0) state_next = DONE;
      DONE:    if (!gnt_req)  state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Output and datapath strobes decoded from the current state
  always_comb begin
    busy     = (state != IDLE);
    grant_go = (state == IDLE)  && any_req;
    cap_go   = (state == DRIVE) && (cnt == '0);
    rel_go   = (state == DONE)  && !gnt_req;
  end

  // Registered datapath: grant latch, hold counter, result capture, acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= 1'b0;
      ptr  <= 1'b0;
      da   <= 1'b0;
      db   <= 1'b0;
      cnt  <= '0;
      res  <= '0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      if (grant_go) begin
        gnt      <= win;
        ptr      <= ~win;
        {da, db} <= win ? code1 : code0;
        cnt      <= HOLD_LOAD;
      end
      if (state == DRIVE && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (cap_go) begin
        res  <= {dw, dx, dy, dz};
        ack0 <= ~gnt;
        ack1 <= gnt;
      end
      if (rel_go) begin
        ack0 <= 1'b0;
        ack1 <= 1'b0;
        da   <= 1'b0;
        db   <= 1'b0;
      end
    end
  end

endmodule
